aes_key_expansion_seq: RTL and testbench
========================================

// Module: aes_key_expansion_seq
// PURPOSE
// - Sequential, multi-mode AES key expander for AES-128, AES-192 and AES-256, selected per request.
// - Computes one 32-bit schedule word per cycle through one shared 4-byte S-box.
// - Holds the finished schedule in an internal word store, read one round key per request.
// - Sits between the key-load interface and the round datapath; replaces the zero-latency fixed-256 expander where LUT count matters.
// PARAMETERS
// - MAX_NK  8  largest key length in words (legal 4, 6, 8); store depth is 4*(MAX_NK+7) words.
// - RD_REG  1  1: rd_key_o registered (1-cycle read latency); 0: combinational read.
// PORTS
// - clk_i           in   1    clock; single clock domain.
// - rst_i           in   1    reset; synchronous, active-high.
// - start_i         in   1    request expansion; accepted when start_i && ready_o.
// - key_len_i       in   2    0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled on accept.
// - key_i           in   256  master key, MSB-aligned: w[0]=key_i[255:224]; unused LSBs ignored.
// - ready_o         out  1    idle, can accept start.
// - busy_o          out  1    expansion in progress.
// - done_o          out  1    one-cycle pulse when the last word is written.
// - keys_valid_o    out  1    full schedule valid; level.
// - err_o           out  1    one-cycle pulse on a rejected start.
// - nr_o            out  4    Nr of the current schedule (10/12/14).
// - rd_round_i      in   4    round key index to read.
// - rd_key_o        out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}; 0 if r > nr_o.
// BEHAVIOUR
// - Reset values (synchronous on rst_i): state IDLE; ready_o=1; busy_o=0; done_o=0; keys_valid_o=0; err_o=0; nr_o=0; rd_key_o=0.
//   - Word store is not cleared.
//   - rst_i during EXPAND aborts and returns to IDLE; the next start is accepted normally.
// - FSM: IDLE -> EXPAND on an accepted legal start; EXPAND -> IDLE after word Total-1 is written.
//   - Total = 4*(Nr+1) = 44/52/60; Nk = 4/6/8.
// - Accept cycle (cycle 0):
//   - Writes w[0..Nk-1] from key_i.
//   - Loads i=Nk, the i-mod-Nk counter to 0, rcon=0x01 and temp=w[Nk-1].
//   - Drops keys_valid_o.
// - EXPAND, one word per cycle, for i = Nk .. Total-1: w[i] = w[i-Nk] ^ f(temp), and temp <= w[i].
//   - If i mod Nk == 0: f = SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon <= xtime(rcon), giving 01,02,..,80,1B,36.
//   - Else if Nk==8 and i mod Nk == 4: f = SubWord(temp).
//   - Else: f = temp.
//   - The modulo uses a wrap counter, not a divider.
// - done_o pulses and keys_valid_o rises in cycle Total-Nk+1 after accept: 41 / 47 / 53.
// - ready_o = IDLE state. A start during EXPAND is ignored: no err_o, no effect.
// - A start while keys_valid_o=1 is accepted; it restarts expansion and keys_valid_o falls.
// - Rejected starts:
//   - key_len_i==3, or selected Nk > MAX_NK.
//   - Effect: err_o pulses in the next cycle; state, nr_o and keys_valid_o unchanged.
// - Reads:
//   - Allowed at any time; data is valid only while keys_valid_o=1. During EXPAND, reads return current store contents.
//   - RD_REG=1: rd_key_o reflects rd_round_i sampled at the previous edge.
// STRUCTURE
// - Shared package aes_pkg: key-length encoding localparams; Nk/Nr/Total lookup functions; xtime(); 256-entry sbox function.
// - Submodule aes_sbox_word: 32-bit SubWord, 4 sbox instances, combinational; exactly one instance in this block.
// - Word store: 4*(MAX_NK+7) x 32 register array with async internal read of w[i-Nk] and a 4-word output mux.
// TESTING
// - AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
//   -> done_o at cycle 41; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 0 = key.
// - AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//   -> done_o at cycle 47; round 12 = e98ba06f448c773c8ecc720401002202.
// - AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   -> done_o at cycle 53; round 14 = fe4890d1e6188d0b046df344706c631e.
// - key_len_i=3 start -> err_o one pulse, ready_o stays 1, keys_valid_o unchanged.
//   - With MAX_NK=4, a start with key_len_i=2 -> err_o pulse.
// - start_i held during EXPAND -> ignored; done_o at the original cycle.
//   - rst_i asserted at cycle 20 -> IDLE, keys_valid_o=0; a following AES-128 run matches vector 1.
// - rd_round_i=11 after an AES-128 run -> rd_key_o=0.
//   - Back-to-back start in the done cycle +1 -> keys_valid_o falls; new schedule correct.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants and helpers: key-length encoding,
// Nk/Nr/Total lookups, GF(2^8) xtime and the forward S-box table.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_BAD = 2'd3;

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nk_of = 4'd4;
      KEY_LEN_192: nk_of = 4'd6;
      KEY_LEN_256: nk_of = 4'd8;
      default:     nk_of = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: nr_of = 4'd10;
      KEY_LEN_192: nr_of = 4'd12;
      KEY_LEN_256: nr_of = 4'd14;
      default:     nr_of = 4'd0;
    endcase
  endfunction

  // Total schedule words, 4*(Nr+1).
  function automatic logic [5:0] total_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: total_of = 6'd44;
      KEY_LEN_192: total_of = 6'd52;
      KEY_LEN_256: total_of = 6'd60;
      default:     total_of = 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0x00 sits in the most significant byte of the flat table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: the AES S-box applied to each byte of a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_expansion_seq.sv
// Sequential AES-128/192/256 key expander: one schedule word per cycle through
// a single shared SubWord unit, results kept in a word store read per round.
module aes_key_expansion_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int RD_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  output logic         err_o,
  output logic [3:0]   nr_o,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o
);

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  // Handshake: a start is taken on any cycle where start_i && ready_o; while
  // busy, start_i is ignored entirely (no error, no restart).
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       mod_q, mod_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [31:0]      temp_q, temp_d;
  logic [3:0]       nk_q, nk_d;
  logic [3:0]       nr_q, nr_d;
  logic [5:0]       total_q, total_d;
  logic             keys_valid_q, keys_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];

  logic [3:0]       nk_new;
  logic             start_ok;
  logic [31:0]      sub_in, sub_out, f_word, old_word, new_word;
  logic             last_word;

  assign nk_new   = nk_of(key_len_i);
  assign start_ok = (key_len_i != KEY_LEN_BAD) && (int'(nk_new) <= MAX_NK);

  // RotWord is only needed on the i mod Nk == 0 step; otherwise temp feeds SubWord directly.
  assign sub_in = (mod_q == 4'd0) ? {temp_q[23:0], temp_q[31:24]} : temp_q;

  aes_sbox_word u_sbox_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    f_word = temp_q;
    if (mod_q == 4'd0) begin
      f_word = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && mod_q == 4'd4) begin
      f_word = sub_out;
    end
  end

  assign old_word  = mem_q[idx_q - IDX_W'(nk_q)];
  assign new_word  = old_word ^ f_word;
  assign last_word = (idx_q == IDX_W'(total_q - 6'd1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mod_d        = mod_q;
    rcon_d       = rcon_q;
    temp_d       = temp_q;
    nk_d         = nk_q;
    nr_d         = nr_q;
    total_d      = total_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    mem_d        = mem_q;
    if (state_q == ST_IDLE) begin
      if (start_i) begin
        if (start_ok) begin
          for (int k = 0; k < 8; k++) begin
            if (k < int'(nk_new)) mem_d[k] = key_i[255 - 32*k -: 32];
            if (k == int'(nk_new) - 1) temp_d = key_i[255 - 32*k -: 32];
          end
          state_d      = ST_EXPAND;
          idx_d        = IDX_W'(nk_new);
          mod_d        = 4'd0;
          rcon_d       = 8'h01;
          nk_d         = nk_new;
          nr_d         = nr_of(key_len_i);
          total_d      = total_of(key_len_i);
          keys_valid_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      mem_d[idx_q] = new_word;
      temp_d       = new_word;
      if (mod_q == 4'd0) rcon_d = xtime(rcon_q);
      mod_d = (mod_q == nk_q - 4'd1) ? 4'd0 : mod_q + 4'd1;
      idx_d = idx_q + IDX_W'(1);
      if (last_word) begin
        state_d      = ST_IDLE;
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      mod_q        <= '0;
      rcon_q       <= 8'h01;
      temp_q       <= '0;
      nk_q         <= '0;
      nr_q         <= '0;
      total_q      <= '0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mod_q        <= mod_d;
      rcon_q       <= rcon_d;
      temp_q       <= temp_d;
      nk_q         <= nk_d;
      nr_q         <= nr_d;
      total_q      <= total_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // The store keeps its contents across reset; keys_valid_o says whether they mean anything.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  logic [IDX_W-1:0] rd_base;
  logic [127:0]     rd_key_d;

  assign rd_base  = IDX_W'({rd_round_i, 2'b00});
  assign rd_key_d = (rd_round_i > nr_q) ? 128'h0 :
                    {mem_q[rd_base],               mem_q[rd_base + IDX_W'(1)],
                     mem_q[rd_base + IDX_W'(2)],   mem_q[rd_base + IDX_W'(3)]};

  if (RD_REG != 0) begin : g_rd_reg
    logic [127:0] rd_key_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) rd_key_q <= '0;
      else       rd_key_q <= rd_key_d;
    end
    assign rd_key_o = rd_key_q;
  end else begin : g_rd_comb
    assign rd_key_o = rd_key_d;
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_EXPAND);
  assign done_o       = done_q;
  assign keys_valid_o = keys_valid_q;
  assign err_o        = err_q;
  assign nr_o         = nr_q;

endmodule

// File: tb/tb_aes_key_expansion_seq.sv
// Directed bench for the sequential AES key expander using FIPS-197 key vectors.
module tb_aes_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [1:0]   key_len_i = 2'd0;
  logic [255:0] key_i = '0;
  logic [3:0]   rd_round_i = 4'd0;

  logic         ready_o, busy_o, done_o, keys_valid_o, err_o;
  logic [3:0]   nr_o;
  logic [127:0] rd_key_o;

  logic         ready_s, busy_s, done_s, keys_valid_s, err_s;
  logic [3:0]   nr_s;
  logic [127:0] rd_key_s;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_expansion_seq #(.MAX_NK(8), .RD_REG(1)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .key_len_i    (key_len_i),
    .key_i        (key_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .keys_valid_o (keys_valid_o),
    .err_o        (err_o),
    .nr_o         (nr_o),
    .rd_round_i   (rd_round_i),
    .rd_key_o     (rd_key_o)
  );

  aes_key_expansion_seq #(.MAX_NK(4), .RD_REG(1)) dut_small (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .key_len_i    (key_len_i),
    .key_i        (key_i),
    .ready_o      (ready_s),
    .busy_o       (busy_s),
    .done_o       (done_s),
    .keys_valid_o (keys_valid_s),
    .err_o        (err_s),
    .nr_o         (nr_s),
    .rd_round_i   (rd_round_i),
    .rd_key_o     (rd_key_s)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] len, input logic [255:0] key);
    key_len_i = len;
    key_i     = key;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  // Called in cycle first_cyc after accept; counts cycles until done_o, bounded.
  task automatic wait_done(input string tag, input int exp_cyc, input int first_cyc);
    int cyc;
    cyc = first_cyc;
    while (!done_o && cyc < 200) begin
      if (err_o) err_seen++;
      step();
      cyc++;
    end
    chk(tag, 128'(cyc), 128'(exp_cyc));
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] round, input logic [127:0] exp);
    rd_round_i = round;
    step();
    chk(tag, rd_key_o, exp);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready",  128'(ready_o), 128'(1));
    chk("rst_busy",   128'(busy_o), 128'(0));
    chk("rst_done",   128'(done_o), 128'(0));
    chk("rst_valid",  128'(keys_valid_o), 128'(0));
    chk("rst_err",    128'(err_o), 128'(0));
    chk("rst_nr",     128'(nr_o), 128'(0));
    chk("rst_rd_key", rd_key_o, 128'h0);
    rst_i = 1'b0;
    step();

    // AES-128
    do_start(2'd0, KEY128);
    chk("a128_busy",  128'(busy_o), 128'(1));
    chk("a128_ready", 128'(ready_o), 128'(0));
    wait_done("a128_done_cyc", 41, 1);
    chk("a128_valid", 128'(keys_valid_o), 128'(1));
    chk("a128_nr",    128'(nr_o), 128'(10));
    step();
    chk("a128_done_pulse", 128'(done_o), 128'(0));
    rd_chk("a128_r0",  4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_chk("a128_r1",  4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
    rd_chk("a128_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_chk("a128_r11", 4'd11, 128'h0);
    chk("small_a128_valid", 128'(keys_valid_s), 128'(1));

    // Illegal key length
    do_start(2'd3, KEY128);
    chk("bad_err",   128'(err_o), 128'(1));
    chk("bad_ready", 128'(ready_o), 128'(1));
    chk("bad_valid", 128'(keys_valid_o), 128'(1));
    chk("bad_nr",    128'(nr_o), 128'(10));
    step();
    chk("bad_err_pulse", 128'(err_o), 128'(0));

    // AES-192 started while the previous schedule is valid
    do_start(2'd1, KEY192);
    chk("a192_valid_fall", 128'(keys_valid_o), 128'(0));
    chk("a192_busy", 128'(busy_o), 128'(1));
    wait_done("a192_done_cyc", 47, 1);
    chk("a192_nr", 128'(nr_o), 128'(12));
    rd_chk("a192_r1",  4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd_chk("a192_r12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
    rd_chk("a192_r13", 4'd13, 128'h0);

    // AES-256; the MAX_NK=4 instance must reject it
    do_start(2'd2, KEY256);
    chk("small_a256_err",   128'(err_s), 128'(1));
    chk("small_a256_ready", 128'(ready_s), 128'(1));
    chk("small_a256_nr",    128'(nr_s), 128'(10));
    wait_done("a256_done_cyc", 53, 1);
    chk("a256_nr", 128'(nr_o), 128'(14));
    rd_chk("a256_r1",  4'd1,  128'h1f352c073b6108d72d9810a30914dff4);
    rd_chk("a256_r2",  4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    rd_chk("a256_r14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    rd_chk("a256_r15", 4'd15, 128'h0);

    // start_i held through the first 20 cycles of expansion
    key_len_i = 2'd0;
    key_i     = KEY128;
    start_i   = 1'b1;
    step();
    err_seen = 0;
    for (int c = 1; c < 20; c++) begin
      if (err_o) err_seen++;
      step();
    end
    start_i = 1'b0;
    wait_done("hold_done_cyc", 41, 20);
    chk("hold_no_err", 128'(err_seen), 128'(0));
    rd_chk("hold_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of an AES-256 expansion
    do_start(2'd2, KEY256);
    for (int c = 1; c < 20; c++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("abort_ready", 128'(ready_o), 128'(1));
    chk("abort_busy",  128'(busy_o), 128'(0));
    chk("abort_valid", 128'(keys_valid_o), 128'(0));
    step();
    chk("abort_idle_ready", 128'(ready_o), 128'(1));
    do_start(2'd0, KEY128);
    wait_done("rerun_done_cyc", 41, 1);
    rd_chk("rerun_r0",  4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_chk("rerun_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Back-to-back: new start in the cycle after done
    do_start(2'd1, KEY192);
    wait_done("b2b_first_done", 47, 1);
    step();
    chk("b2b_valid_before", 128'(keys_valid_o), 128'(1));
    do_start(2'd2, KEY256);
    chk("b2b_valid_fall", 128'(keys_valid_o), 128'(0));
    wait_done("b2b_done_cyc", 53, 1);
    rd_chk("b2b_r14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    rd_chk("b2b_r0",  4'd0,  128'h603deb1015ca71be2b73aef0857d7781);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
